// File: rtl/pacote_cpu.sv
// Shared CPU definitions: opcodes, the default out-of-range instruction
// and the state encoding of the instruction-memory loader.
package pacote_cpu;

    // Primary opcodes (top 6 bits of the instruction word)
    localparam logic [5:0] OP_TIPO_R = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b000010;
    localparam logic [5:0] OP_LOAD   = 6'b100011;
    localparam logic [5:0] OP_STORE  = 6'b101011;
    localparam logic [5:0] OP_JUMP   = 6'b011111;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    // HALT with a zero payload: what the CPU sees outside the loaded program
    localparam logic [31:0] INSTR_FORA_PADRAO = {OP_HALT, 26'd0};

    // Loader states
    localparam logic [1:0] ESTADO_OCIOSA     = 2'd0;
    localparam logic [1:0] ESTADO_CARREGANDO = 2'd1;
    localparam logic [1:0] ESTADO_PRONTA     = 2'd2;

endpackage : pacote_cpu

// File: rtl/ram_instrucoes.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the loader masks stale words.
module ram_instrucoes #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                  clock,
    input  logic                  i_escreve,
    input  logic [ADDR_W-1:0]     i_end_escrita,
    input  logic [DATA_WIDTH-1:0] i_dado,
    input  logic [ADDR_W-1:0]     i_end_leitura,
    output logic [DATA_WIDTH-1:0] o_dado
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    // Write port: one word per accepted handshake
    always_ff @(posedge clock) begin
        if (i_escreve) begin
            r_mem[i_end_escrita] <= i_dado;
        end
    end

    // Zero-latency read so the CPU can fetch in the same cycle as the PC
    assign o_dado = r_mem[i_end_leitura];

endmodule : ram_instrucoes

// File: rtl/memoria_de_instrucoes_carregavel.sv
// Runtime-loadable instruction memory. A boot agent streams the program in
// over a valid/ready port; afterwards the CPU reads it combinationally by PC.
// Addresses beyond the loaded length return INSTR_FORA and raise a flag.
module memoria_de_instrucoes_carregavel
    import pacote_cpu::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 26,
    parameter int                    MEM_SIZE   = 256,
    parameter logic [DATA_WIDTH-1:0] INSTR_FORA = DATA_WIDTH'(INSTR_FORA_PADRAO)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [ADDR_WIDTH-1:0]             pc,
    output logic [DATA_WIDTH-1:0]             instrucao,
    output logic                              fora_de_faixa,
    input  logic                              carga_inicio,
    input  logic                              carga_valido,
    input  logic [DATA_WIDTH-1:0]             carga_dado,
    input  logic                              carga_fim,
    output logic                              carga_pronto,
    output logic                              pronta,
    output logic [$clog2(MEM_SIZE+1)-1:0]     tamanho_programa
);

    // Counter must reach MEM_SIZE itself, hence the +1
    localparam int CW     = $clog2(MEM_SIZE + 1);
    localparam int RAM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CMP_W  = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] ULTIMO_END = CW'(MEM_SIZE - 1);
    localparam logic [CW-1:0] CAPACIDADE = CW'(MEM_SIZE);

    logic [1:0]            r_estado;
    logic [CW-1:0]         r_contador;
    logic [1:0]            w_estado_prox;
    logic [CW-1:0]         w_contador_prox;
    logic                  w_escreve;
    logic                  w_carga_pronto;
    logic                  w_aceita;
    logic                  w_dentro;
    logic [CMP_W-1:0]      w_pc_ext;
    logic [CMP_W-1:0]      w_tam_ext;
    logic [DATA_WIDTH-1:0] w_dado_ram;

    assign w_carga_pronto = (r_estado == ESTADO_CARREGANDO) && (r_contador < CAPACIDADE);
    assign w_aceita       = carga_valido && w_carga_pronto;

    // Next-state and write decision; a start pulse always wins over data/end
    always_comb begin
        w_estado_prox   = r_estado;
        w_contador_prox = r_contador;
        w_escreve       = 1'b0;
        case (r_estado)
            ESTADO_OCIOSA, ESTADO_PRONTA: begin
                if (carga_inicio) begin
                    w_estado_prox   = ESTADO_CARREGANDO;
                    w_contador_prox = '0;
                end
            end
            ESTADO_CARREGANDO: begin
                if (carga_inicio) begin
                    // Restart: the word offered this cycle is dropped
                    w_contador_prox = '0;
                end else begin
                    if (w_aceita) begin
                        w_escreve       = 1'b1;
                        w_contador_prox = r_contador + CW'(1);
                    end
                    if (carga_fim || (w_aceita && (r_contador == ULTIMO_END))) begin
                        w_estado_prox = ESTADO_PRONTA;
                    end
                end
            end
            default: begin
                w_estado_prox   = ESTADO_OCIOSA;
                w_contador_prox = '0;
            end
        endcase
    end

    // State and write-address counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado   <= ESTADO_OCIOSA;
            r_contador <= '0;
        end else begin
            r_estado   <= w_estado_prox;
            r_contador <= w_contador_prox;
        end
    end

    ram_instrucoes #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .ADDR_W     (RAM_AW)
    ) u_ram (
        .clock         (clock),
        .i_escreve     (w_escreve),
        .i_end_escrita (r_contador[RAM_AW-1:0]),
        .i_dado        (carga_dado),
        .i_end_leitura (pc[RAM_AW-1:0]),
        .o_dado        (w_dado_ram)
    );

    // Range compare done one bit wider so MEM_SIZE == 2^ADDR_WIDTH still fits
    assign w_pc_ext  = CMP_W'(pc);
    assign w_tam_ext = CMP_W'(r_contador);
    assign w_dentro  = (r_estado == ESTADO_PRONTA) && (w_pc_ext < w_tam_ext);

    assign instrucao        = w_dentro ? w_dado_ram : INSTR_FORA;
    assign fora_de_faixa    = !w_dentro;
    assign carga_pronto     = w_carga_pronto;
    assign pronta           = (r_estado == ESTADO_PRONTA);
    assign tamanho_programa = r_contador;

endmodule : memoria_de_instrucoes_carregavel
